// File: rtl/ring_ca_pkg.sv
// rtl/ring_ca_pkg.sv - shared ring/CA flit constants and download FSM encodings
package ring_ca_pkg;

    // Flit type codes carried on ctrl alongside every flit; the upload side
    // produces exactly these codes.
    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    localparam int FLIT_W = 16;

    // Download FSM encodings; the value is visible on ic_download_state.
    typedef enum logic [1:0] {
        DL_IDLE = 2'b00,
        DL_RECV = 2'b01,
        DL_FULL = 2'b10,
        DL_RSVD = 2'b11
    } dl_state_e;

endpackage

// File: rtl/ic_download_err_cnt.sv
// rtl/ic_download_err_cnt.sv - 8-bit saturating protocol error counter
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   i_inc    one error this cycle
//   i_clr    synchronous clear; wins over i_inc
//   o_cnt    saturating count, sticks at 255
module ic_download_err_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ic_req_download.sv
// rtl/ic_req_download.sv - reassembles head/body/tail flits into one IC request message
//
// Optional feature macro: IC_REQ_DOWNLOAD_ERR_CNT_EN (adds err_cnt / err_cnt_clr).
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   flit_in           incoming flit
//   ctrl_in           flit type: 01 head, 10 body, 11 tail, 00 invalid
//   v_flit_in         flit_in/ctrl_in valid
//   flits_ack         consumer has taken flits_out this cycle
//   err_cnt_clr       (macro only) synchronous clear of err_cnt
//   err_cnt           (macro only) saturating count of proto_err pulses
//   download_rdy      a flit can be accepted this cycle
//   flits_out         assembled message, head flit in the top bits
//   v_flits_out       flits_out holds a complete message
//   ic_download_state current FSM state
//   proto_err         one-cycle pulse on a protocol violation
module ic_req_download #(
    parameter  int FLIT_W    = ring_ca_pkg::FLIT_W,
    parameter  int NUM_FLITS = 3,
    localparam int MSG_W     = FLIT_W * NUM_FLITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic [1:0]        ctrl_in,
    input  logic              v_flit_in,
    input  logic              flits_ack,
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
    input  logic              err_cnt_clr,
    output logic [7:0]        err_cnt,
`endif
    output logic              download_rdy,
    output logic [MSG_W-1:0]  flits_out,
    output logic              v_flits_out,
    output logic [1:0]        ic_download_state,
    output logic              proto_err
);

    import ring_ca_pkg::*;

    // Index of the tail slot; the counter is two bits wide.
    localparam logic [1:0] LAST_IDX = 2'(NUM_FLITS - 1);

    dl_state_e        r_state;
    dl_state_e        w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [MSG_W-1:0] r_msg;
    logic [MSG_W-1:0] w_msg_nxt;
    logic             r_err;
    logic             w_err;
    logic             w_rdy;
    logic             w_take;

    // Ready is a pure state decode so the ring FIFO never sees a path from ack.
    assign w_rdy  = (r_state != DL_FULL);
    assign w_take = v_flit_in && w_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= DL_IDLE;
            r_cnt   <= 2'd0;
            r_msg   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_msg   <= w_msg_nxt;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_msg_nxt   = r_msg;
        w_err       = 1'b0;

        case (r_state)
            DL_IDLE: begin
                if (w_take) begin
                    if (ctrl_in == CTRL_HEAD) begin
                        w_msg_nxt = '0;
                        w_msg_nxt[MSG_W-1 -: FLIT_W] = flit_in;
                        w_cnt_nxt   = 2'd1;
                        w_state_nxt = DL_RECV;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end

            DL_RECV: begin
                if (w_take) begin
                    if (ctrl_in == CTRL_HEAD) begin
                        // New head restarts assembly; the partial message is dropped.
                        w_msg_nxt = '0;
                        w_msg_nxt[MSG_W-1 -: FLIT_W] = flit_in;
                        w_cnt_nxt = 2'd1;
                        w_err     = 1'b1;
                    end else if ((ctrl_in == CTRL_BODY) && (r_cnt < LAST_IDX)) begin
                        w_msg_nxt[MSG_W-1-int'(r_cnt)*FLIT_W -: FLIT_W] = flit_in;
                        w_cnt_nxt = r_cnt + 2'd1;
                    end else if ((ctrl_in == CTRL_TAIL) && (r_cnt == LAST_IDX)) begin
                        w_msg_nxt[FLIT_W-1:0] = flit_in;
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = DL_FULL;
                    end else begin
                        // Early tail, late body or idle code: abandon the message.
                        w_msg_nxt   = '0;
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = DL_IDLE;
                        w_err       = 1'b1;
                    end
                end
            end

            DL_FULL: begin
                if (flits_ack) begin
                    w_msg_nxt   = '0;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = DL_IDLE;
                end
            end

            default: begin
                w_msg_nxt   = '0;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = DL_IDLE;
            end
        endcase
    end

    assign download_rdy      = w_rdy;
    assign flits_out         = r_msg;
    assign v_flits_out       = (r_state == DL_FULL);
    assign ic_download_state = r_state;
    assign proto_err         = r_err;

`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
    // Counts on the same edge that raises proto_err.
    ic_download_err_cnt u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err),
        .i_clr (err_cnt_clr),
        .o_cnt (err_cnt)
    );
`else
    // No error counter in this build; proto_err is the only error indication.
`endif

endmodule

// File: tb/tb_ic_req_download.sv
// tb/tb_ic_req_download.sv - self-checking bench for ic_req_download
module tb_ic_req_download;

    localparam int FLIT_W    = 16;
    localparam int NUM_FLITS = 3;
    localparam int MSG_W     = FLIT_W * NUM_FLITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FLIT_W-1:0] flit_in = '0;
    logic [1:0]        ctrl_in = 2'b00;
    logic              v_flit_in = 1'b0;
    logic              flits_ack = 1'b0;
    logic              download_rdy;
    logic [MSG_W-1:0]  flits_out;
    logic              v_flits_out;
    logic [1:0]        ic_download_state;
    logic              proto_err;
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
    logic              err_cnt_clr = 1'b0;
    logic [7:0]        err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the flits of the message collected so far, whether
    // the message is complete and waiting, the expected error pulse and count.
    logic [FLIT_W-1:0] m_q[$];
    bit                m_full = 1'b0;
    bit                m_err  = 1'b0;
    int                m_errs = 0;

    ic_req_download #(.FLIT_W(FLIT_W), .NUM_FLITS(NUM_FLITS)) dut (
        .clk               (clk),
        .rst               (rst),
        .flit_in           (flit_in),
        .ctrl_in           (ctrl_in),
        .v_flit_in         (v_flit_in),
        .flits_ack         (flits_ack),
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
        .err_cnt_clr       (err_cnt_clr),
        .err_cnt           (err_cnt),
`endif
        .download_rdy      (download_rdy),
        .flits_out         (flits_out),
        .v_flits_out       (v_flits_out),
        .ic_download_state (ic_download_state),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [MSG_W-1:0] exp_out();
        logic [MSG_W-1:0] r = '0;
        for (int k = 0; k < m_q.size(); k++) r[MSG_W-1-k*FLIT_W -: FLIT_W] = m_q[k];
        return r;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_full) return 2'b10;
        return (m_q.size() == 0) ? 2'b00 : 2'b01;
    endfunction

    // Drive one cycle of inputs, advance the model, then step past the edge.
    task automatic apply(input logic v, input logic [1:0] c, input logic [FLIT_W-1:0] f,
                         input logic a);
        v_flit_in = v;
        ctrl_in   = c;
        flit_in   = f;
        flits_ack = a;
        m_err     = 1'b0;
        if (m_full) begin
            if (a) begin
                m_q.delete();
                m_full = 1'b0;
            end
        end else if (v) begin
            if (m_q.size() == 0) begin
                if (c == 2'b01) m_q.push_back(f);
                else m_err = 1'b1;
            end else if (c == 2'b01) begin
                m_q.delete();
                m_q.push_back(f);
                m_err = 1'b1;
            end else if (c == 2'b10 && m_q.size() < NUM_FLITS - 1) begin
                m_q.push_back(f);
            end else if (c == 2'b11 && m_q.size() == NUM_FLITS - 1) begin
                m_q.push_back(f);
                m_full = 1'b1;
            end else begin
                m_q.delete();
                m_err = 1'b1;
            end
        end
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
        if (err_cnt_clr) m_errs = 0;
        else if (m_err && m_errs < 255) m_errs++;
`else
        if (m_err && m_errs < 255) m_errs++;
`endif
        @(posedge clk);
        #1;
        v_flit_in = 1'b0;
        flits_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        v_flit_in = 1'b0;
        flits_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_q.delete();
        m_full = 1'b0;
        m_err  = 1'b0;
        m_errs = 0;
        rst    = 1'b1;
    endtask

    task automatic send_msg(input logic [FLIT_W-1:0] h, input logic [FLIT_W-1:0] b,
                            input logic [FLIT_W-1:0] t, input int gap);
        apply(1'b1, 2'b01, h, 1'b0);
        repeat (gap) apply(1'b0, 2'b00, 16'h0, 1'b0);
        apply(1'b1, 2'b10, b, 1'b0);
        repeat (gap) apply(1'b0, 2'b00, 16'h0, 1'b0);
        apply(1'b1, 2'b11, t, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ic_download_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00", ic_download_state);
        end
        checks++;
        if (download_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b expected 1", download_rdy);
        end
        checks++;
        if (flits_out !== '0 || v_flits_out !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h v=%b err=%b expected 0/0/0",
                     flits_out, v_flits_out, proto_err);
        end
    endtask

    task automatic test_clean_message();
        int err_seen = 0;
        apply(1'b1, 2'b01, 16'hAAAA, 1'b0);
        err_seen += int'(proto_err);
        apply(1'b1, 2'b10, 16'hBBBB, 1'b0);
        err_seen += int'(proto_err);
        apply(1'b1, 2'b11, 16'hCCCC, 1'b0);
        err_seen += int'(proto_err);
        checks++;
        if (flits_out !== 48'hAAAABBBBCCCC) begin
            errors++;
            $display("FAIL clean_out: got %h expected aaaabbbbcccc", flits_out);
        end
        checks++;
        if (v_flits_out !== 1'b1 || download_rdy !== 1'b0) begin
            errors++;
            $display("FAIL clean_flags: got v=%b rdy=%b expected v=1 rdy=0",
                     v_flits_out, download_rdy);
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL clean_no_err: got %0d pulses expected 0", err_seen);
        end
    endtask

    task automatic test_hold_and_ack();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 2'b01, 16'hDEAD, 1'b0);
            checks++;
            if (flits_out !== 48'hAAAABBBBCCCC || ic_download_state !== 2'b10) begin
                errors++;
                $display("FAIL hold_%0d: got out=%h state=%b expected aaaabbbbcccc/10",
                         i, flits_out, ic_download_state);
            end
        end
        apply(1'b0, 2'b00, 16'h0, 1'b1);
        checks++;
        if (ic_download_state !== 2'b00 || download_rdy !== 1'b1 || flits_out !== '0
            || v_flits_out !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: got state=%b rdy=%b out=%h v=%b expected 00/1/0/0",
                     ic_download_state, download_rdy, flits_out, v_flits_out);
        end
    endtask

    task automatic test_bubbles();
        send_msg(16'hAAAA, 16'hBBBB, 16'hCCCC, 3);
        checks++;
        if (flits_out !== 48'hAAAABBBBCCCC || v_flits_out !== 1'b1) begin
            errors++;
            $display("FAIL bubbles_out: got %h v=%b expected aaaabbbbcccc v=1",
                     flits_out, v_flits_out);
        end
        apply(1'b0, 2'b00, 16'h0, 1'b1);
    endtask

    task automatic test_orphan();
        apply(1'b1, 2'b10, 16'h1111, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || ic_download_state !== 2'b00) begin
            errors++;
            $display("FAIL orphan_err: got err=%b state=%b expected 1/00",
                     proto_err, ic_download_state);
        end
        apply(1'b0, 2'b00, 16'h0, 1'b0);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL orphan_pulse_len: got %b expected 0", proto_err);
        end
        send_msg(16'h0123, 16'h4567, 16'h89AB, 0);
        checks++;
        if (flits_out !== 48'h0123456789AB || flits_out !== exp_out()) begin
            errors++;
            $display("FAIL orphan_recover: got %h expected 0123456789ab", flits_out);
        end
        apply(1'b0, 2'b00, 16'h0, 1'b1);
    endtask

    task automatic test_restart_early_tail();
        apply(1'b1, 2'b01, 16'h1234, 1'b0);
        apply(1'b1, 2'b01, 16'h5678, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || ic_download_state !== 2'b01) begin
            errors++;
            $display("FAIL restart_err: got err=%b state=%b expected 1/01",
                     proto_err, ic_download_state);
        end
        apply(1'b1, 2'b10, 16'h9ABC, 1'b0);
        apply(1'b1, 2'b11, 16'hDEF0, 1'b0);
        checks++;
        if (flits_out[47:32] !== 16'h5678 || flits_out !== exp_out() || v_flits_out !== 1'b1) begin
            errors++;
            $display("FAIL restart_out: got %h v=%b expected %h v=1",
                     flits_out, v_flits_out, exp_out());
        end
        apply(1'b0, 2'b00, 16'h0, 1'b1);
        apply(1'b1, 2'b01, 16'h4444, 1'b0);
        apply(1'b1, 2'b11, 16'h5555, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || ic_download_state !== 2'b00 || flits_out !== '0) begin
            errors++;
            $display("FAIL early_tail: got err=%b state=%b out=%h expected 1/00/0",
                     proto_err, ic_download_state, flits_out);
        end
        apply(1'b0, 2'b00, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid_message();
        apply(1'b1, 2'b01, 16'h7777, 1'b0);
        apply(1'b1, 2'b10, 16'h8888, 1'b0);
        do_reset();
        checks++;
        if (ic_download_state !== 2'b00 || download_rdy !== 1'b1 || flits_out !== '0
            || v_flits_out !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got state=%b rdy=%b out=%h v=%b err=%b expected reset values",
                     ic_download_state, download_rdy, flits_out, v_flits_out, proto_err);
        end
        apply(1'b0, 2'b00, 16'h0, 1'b0);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_err: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       v;
        logic       a;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 6) == 0) c = 2'($urandom_range(0, 3));
            else if (m_q.size() == 0) c = 2'b01;
            else if (m_q.size() < NUM_FLITS - 1) c = 2'b10;
            else c = 2'b11;
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
            err_cnt_clr = ($urandom_range(0, 40) == 0);
`endif
            apply(v, c, 16'($urandom), a);
            checks++;
            if (ic_download_state !== exp_state() || download_rdy !== (exp_state() != 2'b10)
                || v_flits_out !== m_full) begin
                errors++;
                $display("FAIL rand_state_%0d: got state=%b rdy=%b v=%b expected state=%b",
                         i, ic_download_state, download_rdy, v_flits_out, exp_state());
            end
            checks++;
            if (flits_out !== exp_out() || proto_err !== m_err) begin
                errors++;
                $display("FAIL rand_data_%0d: got out=%h err=%b expected out=%h err=%b",
                         i, flits_out, proto_err, exp_out(), m_err);
            end
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
            checks++;
            if (int'(err_cnt) != m_errs) begin
                errors++;
                $display("FAIL rand_errcnt_%0d: got %0d expected %0d", i, err_cnt, m_errs);
            end
`endif
        end
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
    endtask

`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
    task automatic test_err_cnt();
        do_reset();
        for (int i = 0; i < 300; i++) apply(1'b1, 2'b10, 16'($urandom), 1'b0);
        checks++;
        if (err_cnt !== 8'd255 || int'(err_cnt) != m_errs) begin
            errors++;
            $display("FAIL err_cnt_sat: got %0d expected 255", err_cnt);
        end
        err_cnt_clr = 1'b1;
        apply(1'b1, 2'b11, 16'h0, 1'b0);
        err_cnt_clr = 1'b0;
        checks++;
        if (err_cnt !== 8'd0 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL err_cnt_clr: got cnt=%0d err=%b expected 0/1", err_cnt, proto_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_message();
        test_hold_and_ack();
        test_bubbles();
        test_orphan();
        test_restart_early_tail();
        test_reset_mid_message();
        test_random();
`ifdef IC_REQ_DOWNLOAD_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_req_download.md
Name: ic_req_download

Overview:
- Receive-side counterpart of the IC request upload path.
- Accepts a serial stream of 16-bit flits tagged with a 2-bit ctrl code: 01 head, 10 body, 11 tail, 00 idle/invalid.
- Reassembles the stream into one 48-bit message, MSB flit first, then holds it until the consuming cache/CA logic acknowledges it.
- Provides flow control back to the ring-side FIFO and flags protocol violations.

Parameters:
- FLIT_W, 16, width of one flit.
- NUM_FLITS, 3, flits per message; must be ≥2. Body flits per message = NUM_FLITS-2.
- MSG_W, FLIT_W*NUM_FLITS, width of the assembled message. Derived; do not override.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-low reset (rst==0 resets on the clk edge).
- flit_in  in  FLIT_W  Incoming flit.
- ctrl_in  in  2  Flit type: 01 head, 10 body, 11 tail, 00 invalid.
- v_flit_in  in  1  flit_in/ctrl_in valid.
- flits_ack  in  1  Consumer has taken flits_out this cycle.
- download_rdy  out  1  Block can accept a flit this cycle.
- flits_out  out  MSG_W  Assembled message; head flit in the top bits.
- v_flits_out  out  1  flits_out holds a complete message.
- ic_download_state  out  2  Current FSM state, for debug/arbitration.
- proto_err  out  1  One-cycle pulse on a protocol violation.

Behaviour:
- Transfer rule: a flit is accepted only when v_flit_in && download_rdy.
- download_rdy = (state != FULL). Purely a state decode; it does not depend on flits_ack.
- FSM states:
  - IDLE=00: waiting for a head flit.
  - RECV=01: collecting body/tail flits.
  - FULL=10: message held for the consumer.
  - Code 11 unused; recovers to IDLE.
- Flit counter cnt[1:0] holds the index of the next expected flit.
- IDLE:
  - Accepted ctrl 01: store into slot 0, cnt<=1, go to RECV.
  - Accepted any other ctrl: drop the flit, pulse proto_err, stay in IDLE.
- RECV, accepted flit:
  - ctrl 10 and cnt<NUM_FLITS-1: store into slot cnt, cnt++.
  - ctrl 11 and cnt==NUM_FLITS-1: store into the last slot, go to FULL.
  - ctrl 01: restart. Discard the partial message, store into slot 0, cnt<=1, stay in RECV, pulse proto_err.
  - Early tail, late body, or ctrl 00: discard the partial message, clear slots, go to IDLE, pulse proto_err.
- RECV with no valid flit: hold; there is no timeout.
- FULL:
  - v_flits_out=1.
  - On flits_ack: clear the slots, go to IDLE.
  - A flit arriving in the same cycle as flits_ack is not accepted (rdy=0).
- flits_out is registered. Slot k occupies bits [MSG_W-1-k*FLIT_W -: FLIT_W].
- Latency: tail accepted on edge N → v_flits_out=1 after edge N; next message accepted no earlier than one cycle after the ack.
- Back-to-back throughput: one message per NUM_FLITS+1 cycles, plus consumer delay.
- flits_ack outside FULL is ignored.
- Reset values:
  - state IDLE, cnt 0, flits_out 0.
  - v_flits_out 0, proto_err 0, download_rdy 1 once rst deasserts.
- Reset mid-message or in FULL: the partial or held message is lost with no error pulse.

Optional Feature:
- Macro: IC_REQ_DOWNLOAD_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt[7:0], an 8-bit saturating count of proto_err pulses (sticks at 255).
  - Adds input err_cnt_clr (1 bit, synchronous clear). If a clear and an error occur in the same cycle, the clear wins.
  - err_cnt resets to 0.
- When undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Shared package ring_ca_pkg holds:
  - CTRL_IDLE=2'b00, CTRL_HEAD=2'b01, CTRL_BODY=2'b10, CTRL_TAIL=2'b11.
  - FLIT_W=16.
  - Download state encodings.
- These ctrl constants are the same ones the upload side must use.
- Sub-module ic_download_err_cnt holds the saturating counter. It is instantiated only under the macro.
- The FSM and flit slots stay in the top module.

Test Plan:
- Clean message: flits 16'hAAAA/01, 16'hBBBB/10, 16'hCCCC/11 on consecutive cycles → next cycle flits_out=48'hAAAABBBBCCCC, v_flits_out=1, download_rdy=0, proto_err never set.
- Hold and ack: with the message held, ack absent for 5 cycles → output stable, an offered head flit is not accepted. Assert flits_ack → IDLE next cycle, download_rdy=1, flits_out=0.
- Bubbles: same message with v_flit_in low for 3 cycles between each flit → identical result.
- Orphan flits: body 16'h1111/10 while IDLE → dropped, proto_err one pulse, state stays 00. Then a valid message assembles correctly.
- Restart and early tail:
  - Head 16'h1234 then head 16'h5678 → proto_err pulse, then body/tail give flits_out[47:32]=16'h5678.
  - Head then tail → proto_err pulse, back to IDLE.
- Reset during RECV (after head+body) → all outputs at reset values, no proto_err. With IC_REQ_DOWNLOAD_ERR_CNT_EN, 300 orphan flits → err_cnt=255, and err_cnt_clr→0.
